// File: rtl/uart_tx_fifo_if.sv
// CPU-side write port and status of the UART transmitter.
// master = memory/IO block driving the strobe, slave = uart_tx_fifo.
interface uart_tx_fifo_if #(
    parameter int CNT_W = 5
);
    logic             clk_en;
    logic             tx_wen;
    logic [7:0]       tx_data;
    logic             tx_full;
    logic             tx_busy;
    logic [CNT_W-1:0] tx_count;
    logic             tx_overflow;

    modport master (
        output clk_en, tx_wen, tx_data,
        input  tx_full, tx_busy, tx_count, tx_overflow
    );

    modport slave (
        input  clk_en, tx_wen, tx_data,
        output tx_full, tx_busy, tx_count, tx_overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer on o_tx (idle high).
// Define UART_TX_PARITY_EN to add an even-parity bit between data and stop.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    uart_tx_fifo_if.slave  bus,
    output logic           o_tx
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [7:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_busy;
    state_t            r_state;
    logic [7:0]        r_data;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic              r_tx;

    state_t            w_state_nxt;
    logic [7:0]        w_data_nxt;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [2:0]        w_bit_nxt;
    logic              w_tx_nxt;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_baud_end;
    logic [2:0]        w_bit_inc;
    logic [CNT_W-1:0]  w_count_nxt;

    // Full is judged on the pre-edge count, so a same-edge pop never makes room.
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_push      = bus.tx_wen && bus.clk_en && !w_full;
    assign w_baud_end  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_bit_inc   = r_bit + 3'd1;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_baud_nxt  = r_baud + BAUD_W'(1);
        w_bit_nxt   = r_bit;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_data_nxt  = r_mem[r_rd_ptr];
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_data[0];
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_nxt    = ^r_data;
                        w_state_nxt = S_PARITY;
`else
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = w_bit_inc;
                        w_tx_nxt  = r_data[w_bit_inc];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    // Back-to-back frames: next start bit begins on this edge.
                    if (r_count != '0) begin
                        w_pop       = 1'b1;
                        w_data_nxt  = r_mem[r_rd_ptr];
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_baud_nxt  = '0;
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_baud     <= '0;
            r_bit      <= '0;
            r_tx       <= 1'b1;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_data   <= w_data_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_tx     <= w_tx_nxt;
            r_count  <= w_count_nxt;
            r_busy   <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (bus.tx_wen && bus.clk_en && w_full)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= bus.tx_data;
    end

    assign o_tx            = r_tx;
    assign bus.tx_full     = w_full;
    assign bus.tx_busy     = r_busy;
    assign bus.tx_count    = r_count;
    assign bus.tx_overflow = r_overflow;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: frame-countdown reference model checked every cycle,
// plus a serial-line decoder that pops accepted bytes from a scoreboard queue.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0;
    logic rst;
    logic tx;

    uart_tx_fifo_if #(.CNT_W(CNT_W)) bus ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus),
        .o_tx  (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents, cycles left in the current frame, byte on the wire.
    logic [7:0] m_fifo [$];
    logic [7:0] exp_q  [$];
    int         m_rem  = 0;
    logic [7:0] m_cur  = 8'h00;
    logic       m_ovf  = 1'b0;
    int         rst_gen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_tx();
        int p, b;
        if (m_rem == 0) return 1'b1;
        p = FRAME - m_rem;
        b = p / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^m_cur;
`endif
        return 1'b1;
    endfunction

    task automatic cycle(input logic r, input logic w, input logic e, input logic [7:0] d);
        logic full_pre, pop_now;
        rst         = r;
        bus.tx_wen  = w;
        bus.clk_en  = e;
        bus.tx_data = d;
        @(posedge clk);
        if (r) begin
            m_fifo.delete();
            exp_q.delete();
            m_rem = 0;
            m_ovf = 1'b0;
            rst_gen++;
        end else begin
            full_pre = (m_fifo.size() == DEPTH);
            pop_now  = (m_rem <= 1) && (m_fifo.size() > 0);
            if (m_rem > 0) m_rem--;
            if (pop_now) begin
                m_cur = m_fifo.pop_front();
                m_rem = FRAME;
            end
            if (w && e) begin
                if (full_pre) m_ovf = 1'b1;
                else begin
                    m_fifo.push_back(d);
                    exp_q.push_back(d);
                end
            end
        end
        #1;
        bus.tx_data = ~d;
        check("tx",       32'(tx),              32'(model_tx()));
        check("count",    32'(bus.tx_count),    32'(m_fifo.size()));
        check("full",     32'(bus.tx_full),     32'(m_fifo.size() == DEPTH));
        check("busy",     32'(bus.tx_busy),     32'((m_rem > 0) || (m_fifo.size() > 0)));
        check("overflow", 32'(bus.tx_overflow), 32'(m_ovf));
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 4000; i++) begin
            if (m_rem == 0 && m_fifo.size() == 0) break;
            cycle(1'b0, 1'b0, 1'b0, 8'h00);
        end
        checks++;
        if (i >= 4000) begin
            errors++;
            $display("FAIL drain_timeout: got busy expected idle");
        end
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Serial decoder: samples mid-bit after each falling start edge.
    int         mon_gen    = 0;
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte   = 8'h00;

    always @(negedge clk) begin
        int k;
        logic [7:0] e;
        if (mon_gen != rst_gen) begin
            mon_gen    = rst_gen;
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % CPB == CPB / 2) begin
                k = mon_cnt / CPB;
                if (k >= 1 && k <= 8) mon_byte[k-1] = tx;
`ifdef UART_TX_PARITY_EN
                if (k == 9) check("parity_bit", 32'(tx), 32'(^mon_byte));
`endif
                if (k == NBITS - 1) begin
                    check("stop_bit", 32'(tx), 32'd1);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_data: got %0h expected none queued", mon_byte);
                    end else begin
                        e = exp_q.pop_front();
                        if (mon_byte !== e) begin
                            errors++;
                            $display("FAIL frame_data: got %0h expected %0h", mon_byte, e);
                        end
                    end
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.tx_wen  = 1'b0;
        bus.clk_en  = 1'b0;
        bus.tx_data = 8'h00;
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 8'h00);

        cycle(1'b0, 1'b1, 1'b1, 8'hA5);
        drain();

        cycle(1'b0, 1'b1, 1'b1, 8'h01);
        cycle(1'b0, 1'b1, 1'b1, 8'h80);
        drain();

        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 8'(8'h10 + i));
        drain();

        cycle(1'b0, 1'b1, 1'b0, 8'h11);
        cycle(1'b0, 1'b1, 1'b1, 8'h5A);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 8'h22);
        drain();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                for (int j = 0; j < 6; j++) cycle(1'b0, 1'b1, 1'b1, 8'($urandom));
            end else begin
                cycle(1'b0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                      8'($urandom));
            end
        end
        drain();

        cycle(1'b0, 1'b1, 1'b1, 8'hFF);
        cycle(1'b0, 1'b1, 1'b1, 8'h3C);
        cycle(1'b0, 1'b1, 1'b1, 8'hC3);
        for (int i = 0; i < 100 && (m_rem == 0 || (FRAME - m_rem) < 4 * CPB + 1); i++)
            cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (100) cycle(1'b0, 1'b0, 1'b0, 8'h00);

        cycle(1'b0, 1'b1, 1'b1, 8'h07);
        drain();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
